// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package if_pkg;

  localparam logic [4:0] HALT_OPCODE = 5'b11111;

  localparam int unsigned IF_PC_W   = 32;
  localparam int unsigned IF_INST_W = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [IF_PC_W-1:0]   pc;
    logic [IF_INST_W-1:0] inst;
  } if_entry_t;

  function automatic logic is_halt(input logic [4:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/if_queue.sv
// Synchronous prefetch FIFO holding (pc, inst) entries, with whole-queue flush.
module if_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = if_entry_t,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t head,
  output logic [AW:0] count,
  output logic   full,
  output logic   empty
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Pointer and occupancy update; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; data needs no reset since occupancy gates its use.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch unit: PC, RUN/HALT FSM, credit-based issue into a
// prefetch queue, branch redirect with flush, halt on the stop opcode.
// Optional IFQ_BYPASS_EN: an arriving response may drive the outputs
// combinationally when the queue is empty.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned IM_AW  = 7,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              im_en,
  output logic [IM_AW-1:0]  im_addr,
  input  logic [INST_W-1:0] im_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_pc,
  output logic              stop,
  output logic              halted
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_e    state, state_nx;
  logic [PC_W-1:0] pc, pc_nx;
  logic [PC_W-1:0] fetch_pc;
  logic            inflight;
  logic            kill;

  logic [CW-1:0]   count;
  logic            q_full, q_empty, q_push, q_pop;
  entry_t          resp, head;

  logic            issue, live, halt_cap, byp;

  assign resp.pc   = fetch_pc;
  assign resp.inst = im_rdata;

  // A response is live unless a halt in its issue cycle killed it.
  assign live     = inflight && !kill;
  assign halt_cap = live && !branch_taken && is_halt(im_rdata[31:27]);

  // Issue credit and next PC/state; branch beats halt capture beats issue.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    issue    = 1'b0;
    if (rst && state == RUN && !branch_taken && !q_full &&
        (count + CW'(inflight) < CW'(DEPTH)))
      issue = 1'b1;
    if (branch_taken) begin
      state_nx = RUN;
      pc_nx    = branch_pc;
    end else if (halt_cap) begin
      state_nx = HALT;
      pc_nx    = fetch_pc + PC_W'(1);
    end else if (issue) begin
      pc_nx = pc + PC_W'(1);
    end
  end

  // Fetch state, PC and in-flight tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      pc       <= '0;
      fetch_pc <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      inflight <= issue;
      kill     <= issue && halt_cap;
      if (issue) fetch_pc <= pc;
    end
  end

  assign im_en   = issue;
  assign im_addr = pc[IM_AW-1:0];
  assign halted  = (state == HALT);

`ifdef IFQ_BYPASS_EN
  assign byp       = live && !branch_taken && q_empty;
  assign out_valid = !q_empty || byp;
  assign out_inst  = q_empty ? im_rdata : head.inst;
  assign out_pc    = q_empty ? fetch_pc : head.pc;
`else
  assign byp       = 1'b0;
  assign out_valid = !q_empty;
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
`endif

  // A bypassed response that decode accepts never enters the queue.
  assign q_pop  = out_valid && out_ready && !q_empty;
  assign q_push = live && !branch_taken && !(byp && out_ready);
  assign stop   = out_valid && is_halt(out_inst[31:27]);

  if_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (q_push),
    .pop   (q_pop),
    .din   (resp),
    .head  (head),
    .count (count),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed cycle checks plus a randomized run,
// with a program-order delivery model checked every cycle.
module tb_if_fetch_queue;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned IM_AW  = 7;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned INST_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              im_en;
  logic [IM_AW-1:0]  im_addr;
  logic [INST_W-1:0] im_rdata;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic              branch_taken = 1'b0;
  logic [PC_W-1:0]   branch_pc = '0;
  logic              stop;
  logic              halted;

  logic [INST_W-1:0] imem [1 << IM_AW];

  int checks = 0;
  int errors = 0;

  // Delivery model: the next pc decode must see, whether a halt was delivered,
  // and the head that must be held stable.
  logic [PC_W-1:0]   exp_pc;
  bit                done;
  bit                hold;
  logic [PC_W-1:0]   hold_pc;
  logic [INST_W-1:0] hold_inst;
  int                delivered = 0;

  if_fetch_queue #(
    .PC_W   (PC_W),
    .IM_AW  (IM_AW),
    .DEPTH  (DEPTH),
    .INST_W (INST_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .im_en        (im_en),
    .im_addr      (im_addr),
    .im_rdata     (im_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .stop         (stop),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    if (im_en) im_rdata <= imem[im_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic model_loop();
    logic [INST_W-1:0] want;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_pc = '0;
        done   = 1'b0;
        hold   = 1'b0;
      end else begin
        chk("stop_flag", stop, out_valid && (out_inst[31:27] == 5'b11111));
        if (hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_pc", out_pc, hold_pc);
          chk("hold_inst", out_inst, hold_inst);
        end
        if (done) begin
          chk("halt_quiet", out_valid, 0);
          chk("halt_state", halted, 1);
        end
        if (out_valid && out_ready) begin
          want = imem[exp_pc[IM_AW-1:0]];
          chk("model_pc", out_pc, exp_pc);
          chk("model_inst", out_inst, want);
          delivered++;
          if (want[31:27] == 5'b11111) done = 1'b1;
          exp_pc = exp_pc + 1;
        end
        hold      = out_valid && !out_ready && !branch_taken;
        hold_pc   = out_pc;
        hold_inst = out_inst;
        if (branch_taken) begin
          exp_pc = branch_pc;
          done   = 1'b0;
        end
      end
    end
  endtask

  task automatic enter_reset();
    tick();
    rst          = 1'b0;
    branch_taken = 1'b0;
    tick();
    sample();
    chk("rst_im_en", im_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stop", stop, 0);
    chk("rst_halted", halted, 0);
  endtask

  // Leaves the bench at cycle 0 (first cycle with reset released), before its negedge.
  task automatic leave_reset(input logic rdy);
    out_ready = rdy;
    tick();
    rst = 1'b1;
  endtask

  task automatic branch_to(input logic [PC_W-1:0] target);
    tick();
    branch_taken = 1'b1;
    branch_pc    = target;
    sample();
    chk("branch_cycle_im_en", im_en, 0);
  endtask

  initial begin
    int base;
    fork
      model_loop();
    join_none

    // Streaming with decode always ready.
    for (int k = 0; k < (1 << IM_AW); k++) imem[k] = 32'h100 + k;
    enter_reset();
    leave_reset(1'b1);
    sample();
    chk("c0_im_en", im_en, 1);
    chk("c0_im_addr", im_addr, 0);
    chk("c0_valid", out_valid, 0);
    tick(); sample();
    chk("c1_valid", out_valid, 0);
    for (int k = 0; k < 12; k++) begin
      tick(); sample();
      chk("stream_valid", out_valid, 1);
      chk("stream_pc", out_pc, k);
      chk("stream_inst", out_inst, 32'h100 + k);
    end

    // Backpressure fills the queue, then drains in order.
    enter_reset();
    leave_reset(1'b0);
    sample();
    repeat (10) begin tick(); sample(); end
    chk("stall_im_en", im_en, 0);
    chk("stall_valid", out_valid, 1);
    chk("stall_pc", out_pc, 0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      sample();
      chk("drain_valid", out_valid, 1);
      chk("drain_pc", out_pc, i);
    end

    // Branch with 3 entries queued and 1 in flight.
    enter_reset();
    leave_reset(1'b0);
    sample();
    repeat (3) begin tick(); sample(); end
    tick();
    branch_taken = 1'b1;
    branch_pc    = 32'h40;
    out_ready    = 1'b1;
    sample();
    chk("br_head_pc", out_pc, 0);
    chk("br_cycle_im_en", im_en, 0);
    tick(); branch_taken = 1'b0; sample();
    chk("br_n1_im_en", im_en, 1);
    chk("br_n1_im_addr", im_addr, 7'h40);
    chk("br_n1_valid", out_valid, 0);
    tick(); sample();
    chk("br_n2_valid", out_valid, 0);
    tick(); sample();
    chk("br_n3_valid", out_valid, 1);
    chk("br_n3_pc", out_pc, 32'h40);
    chk("br_n3_inst", out_inst, 32'h140);
    repeat (4) begin tick(); sample(); end

    // Halt opcode at address 5.
    enter_reset();
    imem[5] = 32'hF800_0005;
    leave_reset(1'b1);
    sample();
    repeat (7) begin tick(); sample(); end
    chk("halt_stop", stop, 1);
    chk("halt_head_pc", out_pc, 5);
    chk("halt_halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      tick(); sample();
      chk("halt_im_en", im_en, 0);
      chk("halt_valid", out_valid, 0);
    end

    // Branch out of HALT.
    branch_to(32'h10);
    chk("hb_still_halted", halted, 1);
    tick(); branch_taken = 1'b0; sample();
    chk("hb_n1_halted", halted, 0);
    chk("hb_n1_im_en", im_en, 1);
    chk("hb_n1_im_addr", im_addr, 7'h10);
    tick(); sample();
    chk("hb_n2_valid", out_valid, 0);
    tick(); sample();
    chk("hb_n3_valid", out_valid, 1);
    chk("hb_n3_pc", out_pc, 32'h10);
    repeat (3) begin tick(); sample(); end

    // Address wrap at 2^IM_AW while the PC keeps counting.
    branch_to(32'h7F);
    tick(); branch_taken = 1'b0; sample();
    chk("wrap_n1_addr", im_addr, 7'h7F);
    tick(); sample();
    chk("wrap_n2_addr", im_addr, 7'h00);
    tick(); sample();
    chk("wrap_n3_pc", out_pc, 32'h7F);
    chk("wrap_n3_inst", out_inst, 32'h17F);
    tick(); sample();
    chk("wrap_n4_pc", out_pc, 32'h80);
    chk("wrap_n4_inst", out_inst, 32'h100);

    // Mid-stream reset: reset values one edge later (checked inside enter_reset).
    enter_reset();

    // Randomized run with backpressure, redirects and sparse halts.
    for (int k = 0; k < (1 << IM_AW); k++) begin
      if ($urandom_range(0, 19) == 0)
        imem[k] = {5'b11111, 27'(k)};
      else
        imem[k] = {5'($urandom_range(0, 30)), 27'($urandom)};
    end
    leave_reset(1'b1);
    base = delivered;
    repeat (3000) begin
      tick();
      out_ready    = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0)
        branch_pc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else
        branch_pc = 32'($urandom_range(0, 300));
    end
    tick();
    branch_taken = 1'b0;
    sample();
    chk("random_progress", (delivered - base) >= 300, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch unit with a decoupling prefetch queue between instruction memory and decode. It drives a synchronous-read instruction memory, tags each fetched word with its PC, and presents (pc, inst) pairs to decode over a valid/ready handshake. It supports branch redirect with flush of queued and in-flight fetches, and halts fetch on the stop opcode.

## Interface
- `PC_W`, 32: PC width; word-addressed.
- `IM_AW`, 7: instruction-memory address width.
- `DEPTH`, 4: queue entries; power of two, ≥ 4.
- `INST_W`, 32: instruction width.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-low reset.
- `im_en` out 1: read strobe to instruction memory.
- `im_addr` out IM_AW: read address, always `pc[IM_AW-1:0]`.
- `im_rdata` in INST_W: read data; valid the cycle after `im_en`.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: decode accepts head.
- `out_inst` out INST_W: head instruction.
- `out_pc` out PC_W: PC of head instruction.
- `branch_taken` in 1: redirect request.
- `branch_pc` in PC_W: redirect target.
- `stop` out 1: `out_valid` and `out_inst[31:27] == 5'b11111`.
- `halted` out 1: fetch FSM is in HALT.

## Operation
- Fetch FSM states:
  - RUN: issue fetches.
  - HALT: no fetches.
- Issue rule, in RUN: `im_en = (count + inflight < DEPTH) && !branch_taken`.
  - `count` is the registered queue occupancy. `inflight` is a 1-bit flag set when a fetch is issued.
  - On issue, `pc <= pc + 1` modulo 2^PC_W.
  - `im_addr` wraps naturally at 2^IM_AW.
- Capture: a cycle with `inflight` set writes {`fetch_pc`, `im_rdata`} into the queue, unless that response is killed.
- Halt: when a captured instruction has opcode `5'b11111`:
  - The FSM enters HALT and `pc` freezes at the halt PC + 1.
  - The halt instruction is still enqueued and delivered.
  - Any fetch issued in the same cycle is killed.
- Branch (`branch_taken`=1) in any state:
  - A head pop completing that cycle (`out_valid && out_ready`) still counts as delivered.
  - All remaining queue entries are flushed.
  - Any response arriving next cycle is killed, using a 1-bit kill flag.
  - `pc <= branch_pc` and FSM <= RUN. No issue that cycle; fetching resumes the next cycle.
- Reset takes priority over branch. Branch takes priority over halt capture in the same cycle.
- Handshake:
  - `out_inst`/`out_pc` hold stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a pop, except on branch flush or reset.

## Timing
- Reset values:
  - `pc`=0, FSM=RUN, `count`=0, `inflight`=0, kill=0.
  - Outputs: `im_en`=0, `out_valid`=0, `stop`=0, `halted`=0.
- First cycle after reset release: `im_en`=1, `im_addr`=0.
- Fetch-to-output latency: issue in cycle N; data arrives in N+1; `out_valid` in N+2 (no bypass).
- Throughput: 1 instruction/cycle sustained with `out_ready` held high (requires DEPTH ≥ 3).
- Full queue: no issue. Empty queue: `out_valid`=0, and `out_ready` is ignored.
- Simultaneous enqueue and dequeue on a full queue is legal and leaves `count` unchanged. The credit rule guarantees no overflow.
- Redirect penalty: branch at cycle N; target fetched at N+1; target visible at N+3 (N+2 with bypass).

## Configuration
- `IFQ_BYPASS_EN` defined:
  - When the queue is empty and a live response arrives, it drives `out_valid`/`out_inst`/`out_pc` combinationally in the same cycle.
  - If accepted, it is not enqueued. Latency becomes 1 cycle after issue.
- Undefined: all responses pass through the queue registers. Outputs depend only on flops (no `im_rdata` → `out_*` combinational path).

## Structure
- Package `if_pkg`:
  - `HALT_OPCODE` = `5'b11111`.
  - Fetch-state enum {RUN, HALT}.
  - `if_entry_t` struct {pc, inst}.
- Sub-module `if_queue`: synchronous FIFO of `if_entry_t` with `flush`, `push`, `pop`, `count`, `full`, `empty`, and the same clock/reset.
- Top module holds `pc`, the FSM, the inflight/kill flags, the credit logic, and the bypass mux.

## Test plan
- Reset, IM preloaded with addr k = k+0x100, `out_ready`=1 → `out_pc` 0,1,2,… on consecutive cycles from cycle 2; `out_inst` 0x100,0x101,…
- `out_ready`=0 for 10 cycles → `count` saturates at 4, `im_en` deasserts, head stays pc=0; on release, pcs 0–7 delivered in order with no gaps or duplicates.
- Branch to 0x40 while 3 entries are queued and 1 in flight → the next delivered `out_pc` is 0x40; no stale pc reaches the output.
- Opcode `11111` at addr 5 → pcs 0–5 delivered; `stop`=1 with pc=5 at head; `halted`=1; `im_en` stays 0 for 20 cycles.
- Branch to 0x10 while halted → `halted`=0 within 1 cycle; pc 0x10 delivered at N+3.
- PC 127 → 128 → `im_addr` wraps to 0; `out_pc`=128; reset asserted mid-stream → all outputs at reset values next cycle.
